assoc_seq_ctrl: RTL and testbench

ASSOC_SEQ_CTRL -- requirements
Module: assoc_seq_ctrl

---
 rtl/assoc_seq_ctrl_if.sv | 23 ++
 rtl/assoc_seq_ctrl.sv | 88 ++++++++
 tb/tb_assoc_seq_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/assoc_seq_ctrl_if.sv
// assoc_seq_ctrl_if: search handshake, chunk read port and result bus
interface assoc_seq_ctrl_if #(
    parameter int BITWIDTH    = 5,
    parameter int NUM_CHUNKS  = 20,
    parameter int NUM_CLASSES = 26,
    parameter int CNT_W       = 7
);
    localparam int AW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
    localparam int IW = NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1;
    logic                          start;
    logic                          abort;
    logic                          rd_en;
    logic [AW-1:0]                 chunk_addr;
    logic [NUM_CLASSES*BITWIDTH-1:0] and_res;
    logic                          busy;
    logic                          done;
    logic [IW-1:0]                 class_idx;
    logic [CNT_W-1:0]              best_score;
    modport master (output start, abort, and_res,
                    input  rd_en, chunk_addr, busy, done, class_idx, best_score);
    modport slave  (input  start, abort, and_res,
                    output rd_en, chunk_addr, busy, done, class_idx, best_score);
endinterface

// File: rtl/assoc_seq_ctrl.sv
// assoc_seq_ctrl: streams chunks, accumulates per-class popcount scores and picks the best class
module assoc_seq_ctrl #(
    parameter int BITWIDTH    = 5,
    parameter int NUM_CHUNKS  = 20,
    parameter int NUM_CLASSES = 26,
    parameter int CNT_W       = 7
) (
    input logic               clk,
    input logic               rst,
    assoc_seq_ctrl_if.slave   bus
);
    localparam int AW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
    localparam int IW = NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, ARGMAX, DONE} state_t;
    state_t           state, nxt;
    logic             acc_en;
    logic [AW-1:0]    addr;
    logic [IW-1:0]    idx, best_idx, fin_idx, res_idx;
    logic [CNT_W-1:0] best, fin_score, res_score;
    logic [CNT_W-1:0] score [NUM_CLASSES];
    logic             take;

    function automatic logic [CNT_W-1:0] popcnt(input logic [BITWIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < BITWIDTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk) state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = bus.start ? RUN : IDLE;
            RUN:     nxt = bus.abort ? IDLE : (addr == AW'(NUM_CHUNKS-1)) ? DRAIN : RUN;
            DRAIN:   nxt = bus.abort ? IDLE : ARGMAX;
            ARGMAX:  nxt = bus.abort ? IDLE : (idx == IW'(NUM_CLASSES-1)) ? DONE : ARGMAX;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_en = state == RUN;
        bus.busy  = state != IDLE;
        bus.done  = state == DONE;
    end

    // Index 0 seeds the running best; later classes win only on a strict improvement.
    always_comb begin
        take      = idx == '0 || score[idx] > best;
        fin_idx   = take ? idx : best_idx;
        fin_score = take ? score[idx] : best;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_en    <= 1'b0;
            addr      <= '0;
            idx       <= '0;
            best_idx  <= '0;
            best      <= '0;
            res_idx   <= '0;
            res_score <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) score[k] <= '0;
        end else begin
            acc_en <= bus.rd_en;
            addr   <= (state == RUN && nxt == RUN) ? addr + 1'b1 : '0;
            idx    <= state == ARGMAX ? idx + 1'b1 : '0;
            for (int k = 0; k < NUM_CLASSES; k++)
                score[k] <= (state == IDLE && bus.start) ? '0 :
                            acc_en ? score[k] + popcnt(bus.and_res[k*BITWIDTH +: BITWIDTH]) : score[k];
            if (state == ARGMAX) begin
                best_idx <= fin_idx;
                best     <= fin_score;
            end
            if (state == ARGMAX && nxt == DONE) begin
                res_idx   <= fin_idx;
                res_score <= fin_score;
            end
        end
    end

    assign bus.chunk_addr = addr;
    assign bus.class_idx  = res_idx;
    assign bus.best_score = res_score;
endmodule

// File: tb/tb_assoc_seq_ctrl.sv
// tb_assoc_seq_ctrl: directed checks of latency, scoring, tie-break, start/abort/reset handling
module tb_assoc_seq_ctrl;
    localparam int BW = 5, NCH = 20, NCL = 26, CW = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0, bad = 0;
    int   mode = 0;

    assoc_seq_ctrl_if #(.BITWIDTH(BW), .NUM_CHUNKS(NCH), .NUM_CLASSES(NCL), .CNT_W(CW)) bus ();
    assoc_seq_ctrl #(.BITWIDTH(BW), .NUM_CHUNKS(NCH), .NUM_CLASSES(NCL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [NCL*BW-1:0] pat(input int m, input int a);
        logic [NCL*BW-1:0] v;
        v = '0;
        for (int k = 0; k < NCL; k++)
            if ((m == 1 && k == 2) || (m == 2 && (k == 3 || k == 7) && a < 10) ||
                m == 3 || (m == 4 && k == 25))
                v[k*BW +: BW] = '1;
        return v;
    endfunction

    // one-cycle read latency memory model
    always @(posedge clk) bus.and_res <= bus.rd_en ? pat(mode, int'(bus.chunk_addr)) : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int m, input int ei, input int es, input int glitch, input bit hold);
        int n = 1, rd = 0, addr_ok = 1;
        mode = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!bus.done && n < 100) begin
            if (bus.rd_en) begin
                if (int'(bus.chunk_addr) != rd) addr_ok = 0;
                rd++;
            end else if (bus.chunk_addr != '0) addr_ok = 0;
            bus.start = (glitch == n);
            tick();
            n++;
        end
        bus.start = 1'b0;
        chk("done_cycle", n, 48);
        chk("rd_cycles", rd, 20);
        chk("addr_seq", addr_ok, 1);
        chk("class_idx", int'(bus.class_idx), ei);
        chk("best_score", int'(bus.best_score), es);
        bus.start = hold;
        tick();
        bus.start = 1'b0;
        chk("done_pulse", int'(bus.done), 0);
        chk("idle_after", int'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_addr", int'(bus.chunk_addr), 0);
        chk("rst_idx", int'(bus.class_idx), 0);
        chk("rst_score", int'(bus.best_score), 0);
        rst = 1'b0;
        tick();
        run(0, 0, 0, 0, 0);
        run(1, 2, 100, 0, 1);
        run(2, 3, 50, 0, 0);
        run(3, 0, 100, 5, 0);
        mode = 3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("mid_rd_en", int'(bus.rd_en), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", int'(bus.busy), 0);
        chk("rstmid_rd_en", int'(bus.rd_en), 0);
        chk("rstmid_addr", int'(bus.chunk_addr), 0);
        chk("rstmid_idx", int'(bus.class_idx), 0);
        chk("rstmid_score", int'(bus.best_score), 0);
        tick();
        run(4, 25, 100, 0, 0);
        run(1, 2, 100, 0, 0);
        mode = 3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (29) tick();
        chk("argmax_busy", int'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_rd_en", int'(bus.rd_en), 0);
        begin
            int dones = 0;
            repeat (30) begin
                if (bus.done) dones++;
                tick();
            end
            chk("abort_no_done", dones, 0);
        end
        chk("abort_idx", int'(bus.class_idx), 2);
        chk("abort_score", int'(bus.best_score), 100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
